// File: rtl/register_file.sv
// Parametrised register bank: one synchronous write port, two combinational read ports.
// Optional same-cycle write-through forwarding is enabled by defining REGFILE_BYPASS_EN.
module register_file #(
    parameter int WIDTH    = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              WR_EN,
    input  logic [ADDR_W-1:0] WR_ADDR,
    input  logic [WIDTH-1:0]  DIN,
    input  logic [ADDR_W-1:0] RD_ADDR_A,
    input  logic [ADDR_W-1:0] RD_ADDR_B,
    output logic [WIDTH-1:0]  DOUT_A,
    output logic [WIDTH-1:0]  DOUT_B
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] reg_val [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
            if (gi == 0 && ZERO_REG != 0) begin : g_zero
                // Hardwired zero: no storage, writes simply have nowhere to land.
                assign reg_val[gi] = '0;
            end else begin : g_store
                logic [WIDTH-1:0] data_reg;

                always_ff @(posedge CLK) begin
                    if (!Reset) begin
                        data_reg <= '0;
                    end else if (WR_EN && (WR_ADDR == ADDR_W'(gi))) begin
                        data_reg <= DIN;
                    end
                end

                assign reg_val[gi] = data_reg;
            end
        end
    endgenerate

    logic [WIDTH-1:0] stored_a;
    logic [WIDTH-1:0] stored_b;

    assign stored_a = reg_val[RD_ADDR_A];
    assign stored_b = reg_val[RD_ADDR_B];

`ifdef REGFILE_BYPASS_EN
    logic wr_live;
    logic fwd_a;
    logic fwd_b;

    // Forward only writes that will actually be stored at the coming edge.
    always_comb begin
        wr_live = Reset && WR_EN && !((ZERO_REG != 0) && (WR_ADDR == '0));
        fwd_a   = wr_live && (RD_ADDR_A == WR_ADDR);
        fwd_b   = wr_live && (RD_ADDR_B == WR_ADDR);
        DOUT_A  = fwd_a ? DIN : stored_a;
        DOUT_B  = fwd_b ? DIN : stored_b;
    end
`else
    assign DOUT_A = stored_a;
    assign DOUT_B = stored_b;
`endif

endmodule
